multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
// - Multi-cycle RV32I control unit. Replaces the single-cycle main decoder for the shared-memory core.
// - A Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
// - Supports lw/sw/R-type/I-type ALU/beq/jal; illegal opcodes trap.
// - Sits between the IR opcode field and the datapath muxes/enables. Adds a mem_ready wait handshake.
// PARAMETERS
// - MEM_HANDSHAKE  1  1: memory states hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
// - SUPPORT_JAL    1  1: op 1101111 executes JAL; 0: it traps as illegal
// - SUPPORT_ALUI   1  1: op 0010011 executes EXECUTEI; 0: it traps as illegal
// PORTS
// - clk            in   1  core clock, all state on rising edge
// - reset          in   1  synchronous, active-high
// - op             in   7  opcode from IR (valid from DECODE onward)
// - zero           in   1  ALU zero flag
// - mem_ready      in   1  memory access completes this cycle
// - pc_write       out  1  PC enable = pc_update | (branch & zero)
// - adr_src        out  1  0: PC addresses memory, 1: ALUOut
// - mem_read       out  1  memory read strobe
// - mem_write      out  1  memory write strobe
// - ir_write       out  1  latch IR and oldPC
// - reg_write      out  1  register file write enable
// - result_src     out  2  00 ALUOut, 01 Data, 10 ALUResult
// - alu_src_a      out  2  00 PC, 01 oldPC, 10 rs1
// - alu_src_b      out  2  00 rs2, 01 imm, 10 const 4
// - alu_op         out  2  00 add, 01 sub/compare, 10 funct-decoded
// - imm_src        out  3  000 I, 001 S, 010 B, 011 J; combinational from op in every state
// - illegal_instr  out  1  high while in TRAP
// - state_o        out  4  current state encoding (debug)
// BEHAVIOUR
// - Reset:
//   - While reset=1, all strobes (pc_write, mem_*, ir_write, reg_write) = 0, illegal_instr = 0, mux selects = 0.
//   - Next state = FETCH. A mid-instruction reset abandons the instruction with no write issued.
// - Unlisted outputs are 0 in each state. One state per cycle unless it holds.
// - FETCH:
//   - adr_src=0, mem_read=1, src_a=00, src_b=10, alu_op=00, result_src=10.
//   - If mem_ready: ir_write=1, pc_update=1, go to DECODE. Otherwise hold with ir_write=0 and pc_write=0.
// - DECODE: src_a=01, src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
//   - 0000011 or 0100011 -> MEMADR
//   - 0110011 -> EXECUTER
//   - 0010011 -> EXECUTEI
//   - 1100011 -> BEQ
//   - 1101111 -> JAL
//   - anything else -> TRAP
// - MEMADR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
// - MEMREAD: adr_src=1, mem_read=1, result_src=00. Holds until mem_ready, then MEMWB.
// - MEMWB: result_src=01, reg_write=1, then FETCH.
// - MEMWRITE: adr_src=1, mem_write=1 (stays asserted while holding). Holds until mem_ready, then FETCH.
// - EXECUTER: src_a=10, src_b=00, alu_op=10, then ALUWB.
// - EXECUTEI: src_a=10, src_b=01, alu_op=10, then ALUWB.
// - ALUWB: result_src=00, reg_write=1, then FETCH.
// - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. pc_write = zero. Then FETCH.
// - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1 (PC <- ALUOut), then ALUWB.
//   - The ALUWB that follows writes oldPC+4 to rd.
// - TRAP: illegal_instr=1, all strobes 0. Sticky; only reset exits.
// - MEM_HANDSHAKE=0: FETCH, MEMREAD and MEMWRITE each last exactly one cycle.
// - Latency (ready memory): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
// STRUCTURE
// - Package riscv_ctrl_pkg holds:
//   - state localparams (4-bit: FETCH=0 ... TRAP=11)
//   - opcode constants
//   - encodings for result_src, alu_src_a/b, alu_op and imm_src
// - Sub-module imm_src_decoder (op -> imm_src, combinational).
// - FSM: state register plus next-state and output always blocks.
// TESTING
// - reset held 3 cycles, then released with op=0110011, mem_ready=1
//   -> strobes 0 during reset; then FETCH, DECODE, EXECUTER, ALUWB (reg_write=1, result_src=00), FETCH.
// - op=0000011 with mem_ready low for 2 cycles in MEMREAD
//   -> MEMREAD held 3 cycles with mem_read=1 and adr_src=1; then MEMWB with result_src=01, reg_write=1.
// - op=0100011 -> MEMWRITE with mem_write=1; reg_write never 1 for the whole instruction.
// - op=1100011: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. Both return to FETCH.
// - op=1101111 -> JAL with pc_write=1, then ALUWB with reg_write=1.
//   - With SUPPORT_JAL=0 -> TRAP, illegal_instr=1 held 10 cycles until reset.
// - reset asserted during MEMWRITE hold -> mem_write drops to 0 the same cycle; next state FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes
// and datapath mux/ALU/immediate select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select derived purely from the opcode, independent of FSM state.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with a mem_ready wait handshake; unsupported opcodes trap.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_JAL   = 1'b1,
  parameter bit SUPPORT_ALUI  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   rdy;
  logic   pc_update;
  logic   branch;

  assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_o = state_q;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_ALUI:      state_d = SUPPORT_ALUI ? S_EXECUTEI : S_TRAP;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = SUPPORT_JAL ? S_JAL : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (rdy) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode from the current state; reset forces them low in the same
  // cycle so an interrupted instruction never issues a write.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = rdy;
        pc_update  = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_TRAP:     illegal_instr = 1'b1;
      default: ;
    endcase
    pc_write = pc_update | (branch & zero);
    if (reset) begin
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = '0;
      alu_src_a     = '0;
      alu_src_b     = '0;
      alu_op        = '0;
      illegal_instr = 1'b0;
    end
  end

endmodule
